// File: rtl/hex_display_ctrl_if.sv
// Load/value/control inputs and segment/status outputs of the hex display controller.
interface hex_display_ctrl_if #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned WIDTH  = 4 * DIGITS
);
   logic                  load;
   logic [WIDTH-1:0]      value;
   logic                  mode;
   logic                  blank_lz;
   logic [DIGITS-1:0]     blink_en;
   logic [7*DIGITS-1:0]   hex;
   logic                  busy;
   logic                  overflow;

   modport master (
      output load, value, mode, blank_lz, blink_en,
      input  hex, busy, overflow
   );

   modport slave (
      input  load, value, mode, blank_lz, blink_en,
      output hex, busy, overflow
   );
endinterface

// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment driver: hex or double-dabble decimal display,
// leading-zero blanking, per-digit blink and decimal overflow dashes.
module hex_display_ctrl #(
   parameter int unsigned DIGITS    = 4,
   parameter int unsigned WIDTH     = 4 * DIGITS,
   parameter int unsigned BLINK_DIV = 25000000
) (
   input logic               clk,
   input logic               rst_n,
   hex_display_ctrl_if.slave bus
);

   localparam int unsigned DISP_W  = 4 * DIGITS;
   // floor(WIDTH*log10(2))+1 always covers ceil(WIDTH*log10(2)) digits
   localparam int unsigned BCD_MIN = (WIDTH * 1233) / 4096 + 1;
   // one spare digit above DIGITS so the overflow slice is never empty
   localparam int unsigned BCD_N   = ((BCD_MIN > DIGITS) ? BCD_MIN : DIGITS) + 1;
   localparam int unsigned BCD_W   = 4 * BCD_N;
   localparam int unsigned CNT_W   = $clog2(WIDTH + 1);
   localparam int unsigned EXT_W   = (WIDTH > DISP_W) ? WIDTH : DISP_W;
   localparam int unsigned BL_W    = $clog2(BLINK_DIV);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic {IDLE, CONV} state_t;

   state_t               state, state_d;
   logic [WIDTH-1:0]     shreg, shreg_d;
   logic [BCD_W-1:0]     bcd, bcd_d, bcd_step, bcd_shift;
   logic [CNT_W-1:0]     cnt, cnt_d;
   logic [DISP_W-1:0]    disp, disp_d;
   logic [EXT_W-1:0]     value_ext;
   logic                 ovf_q, ovf_d;
   logic                 blank_q, blank_d;
   logic                 busy_q, busy_d;
   logic [7*DIGITS-1:0]  hex_q, hex_d;
   logic [BL_W-1:0]      bl_cnt;
   logic                 phase;
   logic                 nz_seen;
   logic [3:0]           nib;
   logic [6:0]           glyph;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'h0: seg7 = 7'b1000000;
         4'h1: seg7 = 7'b1111001;
         4'h2: seg7 = 7'b0100100;
         4'h3: seg7 = 7'b0110000;
         4'h4: seg7 = 7'b0011001;
         4'h5: seg7 = 7'b0010010;
         4'h6: seg7 = 7'b0000010;
         4'h7: seg7 = 7'b1111000;
         4'h8: seg7 = 7'b0000000;
         4'h9: seg7 = 7'b0010000;
         4'hA: seg7 = 7'b0001000;
         4'hB: seg7 = 7'b0000011;
         4'hC: seg7 = 7'b1000110;
         4'hD: seg7 = 7'b0100001;
         4'hE: seg7 = 7'b0000110;
         default: seg7 = 7'b0001110;
      endcase
   endfunction

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         shreg   <= '0;
         bcd     <= '0;
         cnt     <= '0;
         disp    <= '0;
         ovf_q   <= 1'b0;
         blank_q <= 1'b0;
         busy_q  <= 1'b0;
         hex_q   <= '1;
      end else begin
         state   <= state_d;
         shreg   <= shreg_d;
         bcd     <= bcd_d;
         cnt     <= cnt_d;
         disp    <= disp_d;
         ovf_q   <= ovf_d;
         blank_q <= blank_d;
         busy_q  <= busy_d;
         hex_q   <= hex_d;
      end
   end

   // Next state: load capture in IDLE, one double-dabble step per CONV cycle
   always_comb begin
      state_d   = state;
      shreg_d   = shreg;
      bcd_d     = bcd;
      cnt_d     = cnt;
      disp_d    = disp;
      ovf_d     = ovf_q;
      blank_d   = blank_q;
      value_ext = EXT_W'(bus.value);
      bcd_step  = bcd;
      for (int i = 0; i < int'(BCD_N); i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_step[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      bcd_shift = {bcd_step[BCD_W-2:0], shreg[WIDTH-1]};
      case (state)
         IDLE: begin
            if (bus.load) begin
               blank_d = bus.blank_lz;
               if (bus.mode) begin
                  shreg_d = bus.value;
                  bcd_d   = '0;
                  cnt_d   = '0;
                  state_d = CONV;
               end else begin
                  disp_d = value_ext[DISP_W-1:0];
                  ovf_d  = 1'b0;
               end
            end
         end
         CONV: begin
            bcd_d   = bcd_shift;
            shreg_d = shreg << 1;
            cnt_d   = cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
               disp_d  = bcd_shift[DISP_W-1:0];
               ovf_d   = |bcd_shift[BCD_W-1:DISP_W];
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == CONV);
   end

   // Glyph selection: overflow dashes win, then leading-zero blanking and blink
   always_comb begin
      hex_d   = '1;
      nz_seen = 1'b0;
      nib     = '0;
      glyph   = SEG_BLANK;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         nib   = disp[4*i +: 4];
         glyph = seg7(nib);
         if (nib != 4'd0) nz_seen = 1'b1;
         if (ovf_q)
            glyph = SEG_DASH;
         else if ((blank_q && !nz_seen && i != 0) || (phase && bus.blink_en[i]))
            glyph = SEG_BLANK;
         hex_d[7*i +: 7] = glyph;
      end
   end

   // Free-running blink timebase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bl_cnt <= '0;
         phase  <= 1'b0;
      end else if (bl_cnt == BL_W'(BLINK_DIV - 1)) begin
         bl_cnt <= '0;
         phase  <= ~phase;
      end else begin
         bl_cnt <= bl_cnt + 1'b1;
      end
   end

   assign bus.hex      = hex_q;
   assign bus.busy     = busy_q;
   assign bus.overflow = ovf_q;

endmodule
